vpu_sequencer: RTL
==================

VPU_SEQUENCER -- requirements
Module: vpu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: start  in  1  one-cycle job request, sampled only in IDLE.
REQ-003 SHALL have: mode  in  2  job type, sampled with start: 00 fwd-hidden, 01 fwd-output+loss, 10 backward, 11 passthrough.
REQ-004 SHALL have: num_rows  in  8  vectors per lane for the job, sampled with start.
REQ-005 SHALL have: src_valid  in  1; src_data_1, src_data_2  in  16 signed; src_ready  out  1. This is the source stream handshake.
REQ-006 SHALL have: vpu_data_pathway  out  4; vpu_data_in_1, vpu_data_in_2  out  16; vpu_valid_in_1, vpu_valid_in_2  out  1.
REQ-007 SHALL have: vpu_valid_out_1, vpu_valid_out_2  in  1. These are the returned VPU result strobes.
REQ-008 SHALL have: busy  out  1; done  out  1 (one-cycle pulse); error  out  1 (sticky until next accepted start).

Function
REQ-009 SHALL implement states IDLE, CONFIG, STREAM, DRAIN, DONE, encoded in 3 bits.
REQ-010 SHALL leave IDLE only on start=1 with num_rows!=0, then enter CONFIG.
REQ-011 SHALL treat start with num_rows=0 as follows: go directly to DONE, set error=1, and issue no VPU valids.
REQ-012 SHALL register vpu_data_pathway in CONFIG by mode: 00->1100, 01->1111, 10->0001, 11->0000.
REQ-013 SHALL hold the pathway constant from CONFIG through DONE, and drive 0000 in IDLE.
REQ-014 SHALL spend exactly one cycle in CONFIG with no valids asserted. This is the pathway settle cycle.
REQ-015 In STREAM, SHALL assert src_ready=1 while issued_count<num_rows. src_ready SHALL be 0 in all other states.
REQ-016 SHALL consume a beat when src_valid&src_ready.
REQ-017 SHALL register src_data_1 to vpu_data_in_1 with vpu_valid_in_1=1 on the next cycle, giving 1-cycle latency.
REQ-018 SHALL skew lane 2 by one cycle relative to lane 1: src_data_2 appears on vpu_data_in_2 with vpu_valid_in_2=1 two cycles after acceptance.
REQ-019 Cycles without a handshake SHALL produce a bubble: vpu_valid_in_x=0 for the matching lane slot, and data is held at its last value.
REQ-020 SHALL increment issued_count (8 bits) per accepted beat.
REQ-021 SHALL go to DRAIN on the cycle the num_rows-th beat is accepted.
REQ-022 SHALL keep two 8-bit result counters, res1 and res2, that increment on vpu_valid_out_1 and vpu_valid_out_2 in CONFIG, STREAM and DRAIN.
REQ-023 SHALL saturate res1 and res2 at num_rows.
REQ-024 SHALL set error=1 when a result strobe arrives after its counter has already reached num_rows.
REQ-025 SHALL go DRAIN->DONE when res1==num_rows and res2==num_rows are both true. A final strobe arriving in the same cycle counts toward this.
REQ-026 SHALL run an 8-bit watchdog in DRAIN: it resets on any result strobe and increments otherwise.
REQ-027 When the watchdog reaches 255, SHALL set error=1 and go to DONE.
REQ-028 SHALL spend one cycle in DONE with done=1, then return to IDLE.
REQ-029 SHALL drive busy=1 in CONFIG, STREAM and DRAIN, and 0 in IDLE and DONE.
REQ-030 SHALL ignore start in every state except IDLE. A start arriving in the DONE cycle is dropped.
REQ-031 SHALL clear error on the cycle a start is accepted in IDLE.
REQ-032 SHALL treat all counter compares as unsigned.
REQ-033 SHALL not wrap counters: num_rows max is 255 and the counters stop at num_rows.

Reset
REQ-034 On rst=1, SHALL immediately force the following and hold them while rst=1: state=IDLE, pathway=0000, vpu_data_in_1/2=0, vpu_valid_in_1/2=0, src_ready=0, busy=0, done=0, error=0, all counters and watchdog=0.
REQ-035 SHALL abandon any in-flight job on reset mid-operation. Results arriving after reset release SHALL be ignored in IDLE, with no counting and no error.

Verification
REQ-036 Fwd-hidden: mode=00, num_rows=3, src_valid held high, VPU model 2-cycle latency -> pathway=1100 from CONFIG; lane1 valid 3 consecutive cycles; lane2 same data one cycle later; done pulse 1 cycle after 3rd lane-2 result; error=0.
REQ-037 Backpressure/bubbles: mode=10, num_rows=4, src_valid pattern 1,0,1,1,0,1 -> pathway=0001; vpu_valid_in_1 mirrors accepted beats delayed 1 cycle with bubbles; exactly 4 valids per lane; done asserted.
REQ-038 Zero rows: start with num_rows=0 -> no valids; done=1 the cycle after start; error=1; busy never 1.
REQ-039 Watchdog: mode=01, num_rows=2, VPU returns only 1 lane-2 result -> 255 idle cycles in DRAIN, then error=1 and done=1; pathway=1111 throughout.
REQ-040 Reset mid-STREAM: assert rst after 2 of 5 beats -> all outputs 0 asynchronously; after release, state=IDLE; a new start with mode=11, num_rows=1 completes normally with error=0.
REQ-041 Extra result: num_rows=1, VPU model emits 2 lane-1 strobes -> res1 stays 1; error=1.

Source files
------------

// File: rtl/vpu_sequencer.sv
// Job sequencer for a two-lane VPU. It sets the pathway, streams source beats
// into lane 1 and then lane 2 one cycle later, and counts returned results.
module vpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  num_rows,
  input  logic        src_valid,
  input  logic signed [15:0] src_data_1,
  input  logic signed [15:0] src_data_2,
  output logic        src_ready,
  output logic [3:0]  vpu_data_pathway,
  output logic [15:0] vpu_data_in_1,
  output logic [15:0] vpu_data_in_2,
  output logic        vpu_valid_in_1,
  output logic        vpu_valid_in_2,
  input  logic        vpu_valid_out_1,
  input  logic        vpu_valid_out_2,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  num_rows_q, num_rows_d;
  logic [3:0]  pathway_q, pathway_d;
  logic [7:0]  issued_q, issued_d;
  logic [7:0]  res1_q, res1_d;
  logic [7:0]  res2_q, res2_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        error_q, error_d;
  logic [15:0] data1_q, data1_d;
  logic [15:0] data2_q, data2_d;
  logic [15:0] st2_data_q, st2_data_d;
  logic        valid1_q, valid1_d;
  logic        valid2_q, valid2_d;
  logic        st2_valid_q, st2_valid_d;

  logic start_ok;
  logic accept;
  logic counting;
  logic any_res;

  assign start_ok = (state_q == S_IDLE) && start;
  assign accept   = src_valid && src_ready;
  assign counting = (state_q == S_CONFIG) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign any_res  = vpu_valid_out_1 || vpu_valid_out_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_rows_q  <= '0;
      pathway_q   <= '0;
      issued_q    <= '0;
      res1_q      <= '0;
      res2_q      <= '0;
      wdog_q      <= '0;
      error_q     <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      st2_data_q  <= '0;
      valid1_q    <= 1'b0;
      valid2_q    <= 1'b0;
      st2_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      pathway_q   <= pathway_d;
      issued_q    <= issued_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      wdog_q      <= wdog_d;
      error_q     <= error_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      st2_data_q  <= st2_data_d;
      valid1_q    <= valid1_d;
      valid2_q    <= valid2_d;
      st2_valid_q <= st2_valid_d;
    end
  end

  // Counters, sticky error and the lane pipelines; lane 2 passes through an extra stage.
  always_comb begin
    num_rows_d  = num_rows_q;
    pathway_d   = pathway_q;
    issued_d    = issued_q;
    res1_d      = res1_q;
    res2_d      = res2_q;
    wdog_d      = '0;
    error_d     = error_q;

    if (start_ok) begin
      num_rows_d = num_rows;
      issued_d   = '0;
      res1_d     = '0;
      res2_d     = '0;
      error_d    = (num_rows == 8'd0);
      pathway_d  = 4'b0000;
      if (num_rows != 8'd0) begin
        case (mode)
          2'b00:   pathway_d = 4'b1100;
          2'b01:   pathway_d = 4'b1111;
          2'b10:   pathway_d = 4'b0001;
          default: pathway_d = 4'b0000;
        endcase
      end
    end

    if (accept) issued_d = issued_q + 8'd1;

    if (counting) begin
      if (vpu_valid_out_1) begin
        if (res1_q == num_rows_q) error_d = 1'b1;
        else                      res1_d  = res1_q + 8'd1;
      end
      if (vpu_valid_out_2) begin
        if (res2_q == num_rows_q) error_d = 1'b1;
        else                      res2_d  = res2_q + 8'd1;
      end
    end

    if (state_q == S_DRAIN) begin
      wdog_d = any_res ? 8'd0 : (wdog_q + 8'd1);
      if (wdog_d == 8'hFF) error_d = 1'b1;
    end

    if (state_q == S_DONE) pathway_d = 4'b0000;

    valid1_d    = accept;
    data1_d     = accept ? src_data_1 : data1_q;
    st2_valid_d = accept;
    st2_data_d  = accept ? src_data_2 : st2_data_q;
    valid2_d    = st2_valid_q;
    data2_d     = st2_valid_q ? st2_data_q : data2_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_rows == 8'd0) ? S_DONE : S_CONFIG;
      S_CONFIG: state_d = S_STREAM;
      S_STREAM: if (accept && (issued_d == num_rows_q)) state_d = S_DRAIN;
      S_DRAIN: begin
        if ((res1_d == num_rows_q) && (res2_d == num_rows_q)) state_d = S_DONE;
        else if (wdog_d == 8'hFF)                              state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    src_ready        = (state_q == S_STREAM) && (issued_q < num_rows_q);
    busy             = counting;
    done             = (state_q == S_DONE);
    error            = error_q;
    vpu_data_pathway = pathway_q;
    vpu_data_in_1    = data1_q;
    vpu_data_in_2    = data2_q;
    vpu_valid_in_1   = valid1_q;
    vpu_valid_in_2   = valid2_q;
  end

endmodule
